// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption sequencer: owns the cipher state, walks round keys NR..0 and
// drives a shared inverse-round datapath. Optional macro AES_INV_CTRL_B2B_EN: pop+accept in DONE.
module aes_inv_round_ctrl #(
   parameter int unsigned NR    = 10,
   parameter int unsigned IDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   input  logic              abort,
   output logic              rk_rd_en,
   output logic [IDX_W-1:0]  rk_rd_idx,
   input  logic [127:0]      rk_rd_data,
   output logic [127:0]      dp_state_o,
   output logic [127:0]      dp_rk_o,
   output logic              dp_last_o,
   input  logic [127:0]      dp_result_i,
   output logic              busy,
   output logic [IDX_W-1:0]  round_o
);

   typedef enum logic [1:0] {StIdle, StKeyRd, StApply, StDone} state_e;

   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NR);

   state_e           st_q, st_d;
   logic [127:0]     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= StIdle;
         state_q <= '0;
         idx_q   <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      state_d   = state_q;
      idx_d     = idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_rd_en  = 1'b0;
      dp_last_o = 1'b0;

      unique case (st_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = in_data;
               idx_d   = IdxLast;
               st_d    = StKeyRd;
            end
         end
         StKeyRd: begin
            rk_rd_en = 1'b1;
            st_d     = StApply;
         end
         StApply: begin
            dp_last_o = (idx_q == '0);
            // The initial AddRoundKey has no datapath stage; plain XOR with key NR.
            if (idx_q == IdxLast) begin
               state_d = state_q ^ rk_rd_data;
            end else begin
               state_d = dp_result_i;
            end
            if (idx_q == '0) begin
               st_d = StDone;
            end else begin
               idx_d = idx_q - 1'b1;
               st_d  = StKeyRd;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               st_d = StIdle;
`ifdef AES_INV_CTRL_B2B_EN
               in_ready = ~abort;
               if (in_valid) begin
                  state_d = in_data;
                  idx_d   = IdxLast;
                  st_d    = StKeyRd;
               end
`endif
            end
         end
         default: st_d = StIdle;
      endcase

      // Flush wins over accept, round progress and output handshake alike.
      if (abort) begin
         st_d    = StIdle;
         state_d = '0;
         idx_d   = '0;
      end
   end

   assign out_data   = state_q;
   assign dp_state_o = state_q;
   assign dp_rk_o    = rk_rd_data;
   assign rk_rd_idx  = idx_q;
   assign round_o    = idx_q;
   assign busy       = (st_q != StIdle);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: behavioural AES inverse-round datapath, key RAM and a
// round-level decryption reference model; randomized blocks plus directed scenarios.
module tb_aes_inv_round_ctrl;
   localparam int NR    = 10;
   localparam int IDX_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [127:0]      in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [127:0]      out_data;
   logic              abort = 1'b0;
   logic              rk_rd_en;
   logic [IDX_W-1:0]  rk_rd_idx;
   logic [127:0]      rk_rd_data = '0;
   logic [127:0]      dp_state;
   logic [127:0]      dp_rk;
   logic              dp_last;
   logic [127:0]      dp_result;
   logic              busy;
   logic [IDX_W-1:0]  round_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]   sbox  [0:255];
   logic [7:0]   isbox [0:255];
   logic [127:0] keys  [0:NR];

   int rd_q[$];
   int last_cnt = 0;

   localparam logic [127:0] FipsCt = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FipsPt = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_INV_CTRL_B2B_EN
   localparam int B2bGap = 2 * (NR + 1) + 1;
`else
   localparam int B2bGap = 2 * (NR + 1) + 2;
`endif

   always #5 clk = ~clk;

   aes_inv_round_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .abort(abort),
      .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data),
      .dp_state_o(dp_state), .dp_rk_o(dp_rk), .dp_last_o(dp_last), .dp_result_i(dp_result),
      .busy(busy), .round_o(round_o)
   );

   // ---------------- GF(2^8) and AES round model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0] a [16];
      logic [7:0] t [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int row = 0; row < 4; row++)
         for (int c = 0; c < 4; c++)
            t[row+4*c] = isbox[a[row+4*((c-row+4)%4)]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
            t[4*c]   = gmul(a[0], 14) ^ gmul(a[1], 11) ^ gmul(a[2], 13) ^ gmul(a[3], 9);
            t[4*c+1] = gmul(a[0], 9)  ^ gmul(a[1], 14) ^ gmul(a[2], 11) ^ gmul(a[3], 13);
            t[4*c+2] = gmul(a[0], 13) ^ gmul(a[1], 9)  ^ gmul(a[2], 14) ^ gmul(a[3], 11);
            t[4*c+3] = gmul(a[0], 11) ^ gmul(a[1], 13) ^ gmul(a[2], 9)  ^ gmul(a[3], 14);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r;
   endfunction

   // Whole-block reference: initial key add, then rounds NR-1..0 with the last one short.
   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
      logic [127:0] s = ct ^ keys[NR];
      for (int r = NR - 1; r >= 0; r--) s = inv_round(s, keys[r], r == 0);
      return s;
   endfunction

   task automatic build_sboxes();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h01;
         logic [7:0] s;
         for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic load_fips_keys();
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rcon = 8'h01;
      logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
            tmp = tmp ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= NR; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   assign dp_result = inv_round(dp_state, dp_rk, dp_last);

   // Key RAM: one-cycle read latency.
   always @(posedge clk) if (rk_rd_en) rk_rd_data <= keys[rk_rd_idx];

   always @(negedge clk) begin
      if (rk_rd_en) rd_q.push_back(int'(rk_rd_idx));
      if (dp_last) last_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic wait_out_valid(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   // Offers ct in IDLE, checks latency and plaintext, then pops it.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input string name);
      int cnt;
      @(negedge clk);
      rd_q.delete();
      last_cnt = 0;
      in_valid = 1'b1;
      in_data  = ct;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out_valid(cnt);
      n_checks++;
      if (cnt !== 2 * (NR + 1)) $display("FAIL %s latency: got %0d want %0d", name, cnt, 2 * (NR + 1));
      else n_pass++;
      n_checks++;
      if (out_data !== exp) $display("FAIL %s data: got %h want %h", name, out_data, exp);
      else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL %s pop: busy=%b out_valid=%b want 0 0", name, busy, out_valid);
      else n_pass++;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy, rk_rd_en, dp_last} !== 5'b10000)
         $display("FAIL reset_ctrl: got in_ready/out_valid/busy/rk_rd_en/dp_last=%b want 10000",
                  {in_ready, out_valid, busy, rk_rd_en, dp_last});
      else n_pass++;
      n_checks++;
      if (out_data !== '0 || dp_state !== '0 || round_o !== '0 || rk_rd_idx !== '0)
         $display("FAIL reset_data: got out_data=%h round=%0d idx=%0d want zeros",
                  out_data, round_o, rk_rd_idx);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
      else n_pass++;
   endtask

   task automatic test_fips();
      load_fips_keys();
      run_block(FipsCt, FipsPt, "fips");
      n_checks++;
      if (rd_q.size() !== NR + 1) $display("FAIL key_count: got %0d want %0d", rd_q.size(), NR + 1);
      else n_pass++;
      for (int i = 0; i < rd_q.size() && i <= NR; i++) begin
         n_checks++;
         if (rd_q[i] !== NR - i) $display("FAIL key_order[%0d]: got %0d want %0d", i, rd_q[i], NR - i);
         else n_pass++;
      end
      n_checks++;
      if (last_cnt !== 1) $display("FAIL dp_last_cycles: got %0d want 1", last_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int b = 0; b < 4; b++) begin
         logic [127:0] ct;
         for (int r = 0; r <= NR; r++) keys[r] = {$urandom, $urandom, $urandom, $urandom};
         ct = {$urandom, $urandom, $urandom, $urandom};
         run_block(ct, ref_decrypt(ct), $sformatf("random%0d", b));
      end
      load_fips_keys();
   endtask

   task automatic test_backpressure();
      int cnt;
      int bad_data = 0, bad_ctl = 0, rd_seen = 0;
      logic [127:0] snap;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = FipsCt;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out_valid(cnt);
      snap = out_data;
      n_checks++;
      if (snap !== FipsPt) $display("FAIL bp_data: got %h want %h", snap, FipsPt);
      else n_pass++;
      in_valid = 1'b1;
      in_data  = ~FipsCt;
      repeat (50) begin
         @(negedge clk);
         if (out_data !== snap) bad_data++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad_ctl++;
         if (rk_rd_en) rd_seen++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (bad_data !== 0) $display("FAIL bp_stable: got %0d changed cycles want 0", bad_data);
      else n_pass++;
      n_checks++;
      if (bad_ctl !== 0) $display("FAIL bp_ctrl: got %0d bad cycles want 0", bad_ctl);
      else n_pass++;
      n_checks++;
      if (rd_seen !== 0) $display("FAIL bp_key_reads: got %0d want 0", rd_seen);
      else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== snap)
         $display("FAIL bp_release: got busy=%b out_valid=%b data=%h want 0 0 %h",
                  busy, out_valid, out_data, snap);
      else n_pass++;
   endtask

   task automatic test_abort();
      int cnt = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = FipsCt;
      @(negedge clk);
      in_valid = 1'b0;
      while (!(rk_rd_en && rk_rd_idx == 5) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt >= 50) $display("FAIL abort_reach_idx5: got timeout want key read of idx 5");
      else n_pass++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({busy, out_valid, in_ready, rk_rd_en} !== 4'b0010 || out_data !== '0)
         $display("FAIL abort_mid: got busy/out_valid/in_ready/rk_rd_en=%b data=%h want 0010 0",
                  {busy, out_valid, in_ready, rk_rd_en}, out_data);
      else n_pass++;
      // abort in IDLE drops a concurrent offer
      abort    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy);
      else n_pass++;
      // abort in DONE beats a simultaneous pop and accept
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out_valid(cnt);
      abort     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0)
         $display("FAIL abort_done: got busy=%b out_valid=%b data=%h want 0 0 0",
                  busy, out_valid, out_data);
      else n_pass++;
      run_block(FipsCt, FipsPt, "after_abort");
   endtask

   task automatic test_reset_mid();
      int cnt = 0, ov_seen = 0, busy_seen = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = FipsCt;
      @(negedge clk);
      in_valid = 1'b0;
      while (!(busy && round_o == 3) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, out_valid, in_ready, rk_rd_en} !== 4'b0010 || out_data !== '0 || round_o !== '0)
         $display("FAIL reset_mid: got busy/out_valid/in_ready/rk_rd_en=%b data=%h round=%0d want 0010 0 0",
                  {busy, out_valid, in_ready, rk_rd_en}, out_data, round_o);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
         if (busy) busy_seen++;
      end
      n_checks++;
      if (ov_seen !== 0 || busy_seen !== 0 || in_ready !== 1'b1)
         $display("FAIL reset_after: got out_valid cycles=%0d busy cycles=%0d in_ready=%b want 0 0 1",
                  ov_seen, busy_seen, in_ready);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n = 0, first = -1, second = -1;
      logic [127:0] d1 = '0, d2 = '0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = FipsCt;
      while (second < 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (out_valid) begin
            if (first < 0) begin
               first = n;
               d1 = out_data;
            end else begin
               second = n;
               d2 = out_data;
            end
         end else if (first >= 0 && busy) begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (second - first !== B2bGap)
         $display("FAIL b2b_gap: got %0d want %0d", second - first, B2bGap);
      else n_pass++;
      n_checks++;
      if (d1 !== FipsPt || d2 !== FipsPt)
         $display("FAIL b2b_data: got %h %h want %h", d1, d2, FipsPt);
      else n_pass++;
   endtask

   initial begin
      build_sboxes();
      load_fips_keys();
      test_reset();
      test_fips();
      test_random();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
